// File: rtl/axi_lite_mem_fill_ctrl.sv
// AXI-Lite master that fills a contiguous word region with a constant or
// incrementing pattern, optionally reading it back and counting mismatches.
module axi_lite_mem_fill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    verify_en,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    num_words,
    input  logic [DATA_WIDTH-1:0]   pattern,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
    output logic                    M_AXI_awvalid,
    input  logic                    M_AXI_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
    output logic                    M_AXI_wvalid,
    input  logic                    M_AXI_wready,
    input  logic [1:0]              M_AXI_bresp,
    input  logic                    M_AXI_bvalid,
    output logic                    M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
    output logic                    M_AXI_arvalid,
    input  logic                    M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
    input  logic [1:0]              M_AXI_rresp,
    input  logic                    M_AXI_rvalid,
    output logic                    M_AXI_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);
    localparam logic [CNT_WIDTH-1:0]  ERR_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_FINISH
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, num_q, num_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  pat_q, pat_d, data_q, data_d;
    logic                   mode_q, mode_d, ver_q, ver_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                   bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                   busy_q, busy_d, done_q, done_d, rerr_q, rerr_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, last_word;
    logic [CNT_WIDTH-1:0] err_inc;

    assign aw_hs     = awvalid_q & M_AXI_awready;
    assign w_hs      = wvalid_q & M_AXI_wready;
    assign b_hs      = bready_q & M_AXI_bvalid;
    assign ar_hs     = arvalid_q & M_AXI_arready;
    assign r_hs      = rready_q & M_AXI_rvalid;
    assign last_word = (cnt_q + CNT_WIDTH'(1)) == num_q;
    assign err_inc   = (err_q == ERR_MAX) ? err_q : err_q + CNT_WIDTH'(1);

    // Next-state and datapath; word address/data advance incrementally.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        err_d     = err_q;
        base_d    = base_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        data_d    = data_q;
        mode_d    = mode_q;
        ver_d     = ver_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rerr_d    = rerr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    ver_d  = verify_en;
                    base_d = base_addr & ALIGN_MASK;
                    addr_d = base_addr & ALIGN_MASK;
                    pat_d  = pattern;
                    data_d = pattern;
                    num_d  = num_words;
                    cnt_d  = '0;
                    err_d  = '0;
                    rerr_d = 1'b0;
                    if (num_words == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            S_WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (M_AXI_bresp != 2'b00) begin
                        rerr_d = 1'b1;
                        err_d  = err_inc;
                    end
                    if (!last_word) begin
                        cnt_d     = cnt_q + CNT_WIDTH'(1);
                        addr_d    = addr_q + ADDR_WIDTH'(STRB_W);
                        data_d    = data_q + DATA_WIDTH'(mode_q);
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else if (ver_q) begin
                        cnt_d     = '0;
                        addr_d    = base_q;
                        data_d    = pat_q;
                        state_d   = S_RD_REQ;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    // One error per word even when both response and data are bad.
                    if (M_AXI_rresp != 2'b00 || M_AXI_rdata != data_q) begin
                        err_d = err_inc;
                    end
                    if (M_AXI_rresp != 2'b00) begin
                        rerr_d = 1'b1;
                    end
                    if (last_word) begin
                        state_d = S_FINISH;
                    end else begin
                        cnt_d     = cnt_q + CNT_WIDTH'(1);
                        addr_d    = addr_q + ADDR_WIDTH'(STRB_W);
                        data_d    = data_q + DATA_WIDTH'(mode_q);
                        state_d   = S_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        done_d = (state_d == S_FINISH);
        busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            err_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            pat_q     <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
            ver_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            err_q     <= err_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            ver_q     <= ver_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rerr_q    <= rerr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_q;
    assign resp_err      = rerr_q;
    assign M_AXI_awaddr  = addr_q;
    assign M_AXI_araddr  = addr_q;
    assign M_AXI_wdata   = data_q;
    assign M_AXI_wstrb   = '1;
    assign M_AXI_awvalid = awvalid_q;
    assign M_AXI_wvalid  = wvalid_q;
    assign M_AXI_bready  = bready_q;
    assign M_AXI_arvalid = arvalid_q;
    assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_mem_fill_ctrl.sv
// Bench for axi_lite_mem_fill_ctrl: AXI-Lite RAM slave model plus a per-cycle
// checker against an arithmetic model of the expected word sequence.
module tb_axi_lite_mem_fill_ctrl;

    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic        start = 1'b0, mode = 1'b0, verify_en = 1'b0;
    logic [31:0] base_addr = '0, pattern = '0;
    logic [15:0] num_words = '0;
    logic        busy, done, resp_err;
    logic [15:0] err_count;
    logic [31:0] M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready;
    logic        M_AXI_awready = 1'b0, M_AXI_wready = 1'b0, M_AXI_bvalid = 1'b0;
    logic        M_AXI_arready = 1'b0, M_AXI_rvalid = 1'b0;
    logic [1:0]  M_AXI_bresp = '0, M_AXI_rresp = '0;
    logic [31:0] M_AXI_rdata = '0;

    axi_lite_mem_fill_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode), .verify_en(verify_en),
        .base_addr(base_addr), .num_words(num_words), .pattern(pattern),
        .busy(busy), .done(done), .err_count(err_count), .resp_err(resp_err),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
        .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wvalid(M_AXI_wvalid),
        .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
        .M_AXI_bready(M_AXI_bready), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arvalid(M_AXI_arvalid),
        .M_AXI_arready(M_AXI_arready), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
        .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
    );

    always #5 ACLK = ~ACLK;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // Model state and slave configuration
    logic [31:0] exp_addr [16], exp_data [16], log_a [16], log_d [16];
    logic [31:0] mem [logic [31:0]];
    int  exp_num = 0, exp_err = 0;
    bit  exp_re = 0;
    int  wr_idx = 0, rd_idx = 0, done_cnt = 0, done_cyc = 0, run_cyc = 0, valid_cyc = 0, aw_only = 0;
    int  b_lat = 0, r_lat = 0, b_cnt = 0, r_cnt = 0, aw_stall_cfg = 0, aw_stall_left = 0;
    int  berr_idx = -1, cor_idx = -1, rerr_idx = -1, r_word = 0;
    bit  in_run = 0, accept_next = 0, wr_open = 0, rd_open = 0, have_aw = 0, have_w = 0;
    bit  b_pend = 0, r_pend = 0, b_err_pend = 0;
    bit  aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_hs_q = 0, w_hs_q = 0, ar_hs_q = 0, b_hs_q = 0, r_hs_q = 0;
    logic [31:0] aw_a = '0, w_d = '0, r_addr = '0;

    // Slave model and per-cycle checker; readies/responses change on negedge only.
    always @(negedge ACLK) begin
        if (ARESET) begin
            chk("rst_outputs", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid,
                                M_AXI_rready, busy, done}, 0);
            chk("rst_err", {resp_err, err_count}, 0);
            M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_arready = 0;
            M_AXI_bvalid = 0; M_AXI_rvalid = 0;
            in_run = 0; accept_next = 0; wr_open = 0; rd_open = 0; have_aw = 0; have_w = 0;
            b_pend = 0; r_pend = 0; aw_hs_q = 0; w_hs_q = 0; ar_hs_q = 0; b_hs_q = 0; r_hs_q = 0;
            aw_stall_left = aw_stall_cfg;
        end else begin
            if (accept_next) begin
                in_run = 1; accept_next = 0; run_cyc = 0;
            end
            if (b_hs_q) M_AXI_bvalid = 0;
            if (r_hs_q) M_AXI_rvalid = 0;
            if (b_pend) begin
                if (b_cnt == 0) begin
                    M_AXI_bvalid = 1; M_AXI_bresp = b_err_pend ? 2'b10 : 2'b00; b_pend = 0;
                end else b_cnt--;
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    M_AXI_rdata = (mem.exists(r_addr) ? mem[r_addr] : 32'h0) ^
                                  ((r_word == cor_idx) ? 32'h0000_0100 : 32'h0);
                    M_AXI_rresp = (r_word == rerr_idx) ? 2'b10 : 2'b00;
                    M_AXI_rvalid = 1; r_pend = 0;
                end else r_cnt--;
            end
            if (M_AXI_awvalid && aw_stall_left > 0) begin
                M_AXI_awready = 0; aw_stall_left--;
            end else M_AXI_awready = 1;
            M_AXI_wready = 1; M_AXI_arready = 1;

            aw_hs = M_AXI_awvalid && M_AXI_awready;
            w_hs  = M_AXI_wvalid && M_AXI_wready;
            b_hs  = M_AXI_bvalid && M_AXI_bready;
            ar_hs = M_AXI_arvalid && M_AXI_arready;
            r_hs  = M_AXI_rvalid && M_AXI_rready;

            if (aw_hs_q) chk("aw_drop", M_AXI_awvalid, 0);
            if (w_hs_q)  chk("w_drop", M_AXI_wvalid, 0);
            if (ar_hs_q) chk("ar_drop", M_AXI_arvalid, 0);
            if ((M_AXI_awvalid || M_AXI_wvalid) && !wr_open)
                chk("aw_w_together", {M_AXI_awvalid, M_AXI_wvalid}, 2'b11);
            if (M_AXI_awvalid || M_AXI_wvalid) begin
                chk("wr_while_rd", rd_open, 0);
                wr_open = 1;
            end
            if (M_AXI_arvalid) begin
                chk("rd_while_wr", wr_open, 0);
                rd_open = 1;
            end
            if (M_AXI_awvalid && wr_idx < 16) chk("awaddr", M_AXI_awaddr, exp_addr[wr_idx]);
            if (M_AXI_wvalid && wr_idx < 16) begin
                chk("wdata", M_AXI_wdata, exp_data[wr_idx]);
                chk("wstrb", M_AXI_wstrb, 4'hF);
            end
            if (M_AXI_arvalid && rd_idx < 16) chk("araddr", M_AXI_araddr, exp_addr[rd_idx]);
            if (M_AXI_awvalid || M_AXI_wvalid || M_AXI_arvalid) valid_cyc++;
            if (M_AXI_awvalid && !M_AXI_wvalid) aw_only++;

            if (aw_hs) begin
                have_aw = 1; aw_a = M_AXI_awaddr; aw_stall_left = aw_stall_cfg;
            end
            if (w_hs) begin
                have_w = 1; w_d = M_AXI_wdata;
            end
            if (have_aw && have_w) begin
                chk("write_in_range", wr_idx < exp_num, 1);
                mem[aw_a] = w_d;
                if (wr_idx < 16) begin
                    log_a[wr_idx] = aw_a; log_d[wr_idx] = w_d;
                end
                b_err_pend = (wr_idx == berr_idx);
                wr_idx++; b_pend = 1; b_cnt = b_lat; have_aw = 0; have_w = 0;
            end
            if (ar_hs) begin
                chk("read_in_range", rd_idx < exp_num, 1);
                r_addr = M_AXI_araddr; r_word = rd_idx; rd_idx++; r_pend = 1; r_cnt = r_lat;
            end
            if (b_hs) wr_open = 0;
            if (r_hs) rd_open = 0;

            if (in_run) begin
                run_cyc++;
                if (done) begin
                    done_cnt++; done_cyc = run_cyc; in_run = 0;
                    chk("busy_in_done", busy, 0);
                end else chk("busy_run", busy, 1);
            end else begin
                chk("idle_done", done, 0);
                chk("idle_busy", busy, 0);
            end
            aw_hs_q = aw_hs; w_hs_q = w_hs; ar_hs_q = ar_hs; b_hs_q = b_hs; r_hs_q = r_hs;
            if (start && !in_run && !accept_next) accept_next = 1;
        end
    end

    // Build the expected word sequence and error totals from the run parameters.
    task automatic prep(input logic [31:0] base, input int num, input logic md,
                        input logic [31:0] pat, input logic ver);
        logic [31:0] b;
        b = base & ~32'h3;
        for (int i = 0; i < 16; i++) begin
            exp_addr[i] = b + 32'(i * 4);
            exp_data[i] = md ? pat + 32'(i) : pat;
        end
        exp_num = num; exp_err = 0; exp_re = 0;
        for (int i = 0; i < num; i++) begin
            if (i == berr_idx) begin exp_err++; exp_re = 1; end
            if (ver && (i == cor_idx || i == rerr_idx)) exp_err++;
            if (ver && i == rerr_idx) exp_re = 1;
        end
        wr_idx = 0; rd_idx = 0; done_cnt = 0; done_cyc = 0; valid_cyc = 0; aw_only = 0;
        aw_stall_left = aw_stall_cfg;
        @(posedge ACLK); #1;
        start = 1; mode = md; verify_en = ver; base_addr = base;
        num_words = 16'(num); pattern = pat;
        @(posedge ACLK); #1;
        start = 0;
    endtask

    task automatic finish_chk(input logic ver, input bit extra);
        if (extra) begin
            repeat (3) @(posedge ACLK);
            #1 start = 1; base_addr = 32'h900; pattern = 32'h5555; num_words = 16'd1; mode = ~mode;
            @(posedge ACLK); #1 start = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt != 0) break;
            @(posedge ACLK);
        end
        chk("done_timeout", done_cnt != 0, 1);
        repeat (4) @(posedge ACLK);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("writes", wr_idx, exp_num);
        chk("reads", rd_idx, ver ? exp_num : 0);
        chk("err_count", err_count, exp_err);
        chk("resp_err", resp_err, exp_re);
    endtask

    initial begin
        logic [31:0] lit_a [4];
        logic [31:0] lit_d [4];
        repeat (2) @(posedge ACLK);
        #1;
        chk("reset_valids", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready}, 0);
        chk("reset_status", {busy, done, resp_err, err_count}, 0);
        chk("reset_addr", {M_AXI_awaddr, M_AXI_araddr}, 0);
        ARESET = 0;

        // Incrementing fill with verify
        prep(32'h100, 4, 1'b1, 32'h10, 1'b1);
        finish_chk(1'b1, 1'b0);
        lit_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        lit_d = '{32'h10, 32'h11, 32'h12, 32'h13};
        for (int i = 0; i < 4; i++) begin
            chk("lit_inc_addr", log_a[i], lit_a[i]);
            chk("lit_inc_data", log_d[i], lit_d[i]);
        end
        chk("lit_inc_err", err_count, 0);

        // Zero words: done one cycle after accept, no traffic
        prep(32'h200, 0, 1'b0, 32'h1, 1'b1);
        finish_chk(1'b1, 1'b0);
        chk("zero_done_cycle", done_cyc, 1);
        chk("zero_no_valids", valid_cyc, 0);

        // AWREADY stalled 3 cycles per write, slow responses
        aw_stall_cfg = 3; b_lat = 2; r_lat = 1;
        prep(32'h200, 4, 1'b0, 32'hA5A5_A5A5, 1'b0);
        finish_chk(1'b0, 1'b0);
        chk("aw_only_cycles", aw_only, 12);
        aw_stall_cfg = 0; b_lat = 0; r_lat = 0;

        // Misaligned base is rounded down to a word boundary
        prep(32'h103, 2, 1'b0, 32'h77, 1'b0);
        finish_chk(1'b0, 1'b0);
        chk("lit_align0", log_a[0], 32'h100);
        chk("lit_align1", log_a[1], 32'h104);

        // Corrupt rdata on word 2, RRESP error on word 3
        cor_idx = 2; rerr_idx = 3;
        prep(32'h300, 4, 1'b1, 32'h1000, 1'b1);
        finish_chk(1'b1, 1'b0);
        chk("lit_corrupt_err", err_count, 2);
        chk("lit_corrupt_rerr", resp_err, 1);
        repeat (5) @(posedge ACLK);
        #1 chk("err_hold", err_count, 2);

        // BRESP error on word 0, data and RRESP both bad on word 1
        berr_idx = 0; cor_idx = 1; rerr_idx = 1;
        prep(32'h400, 3, 1'b0, 32'hDEAD_BEEF, 1'b1);
        finish_chk(1'b1, 1'b0);
        chk("lit_once_per_word", err_count, 2);
        berr_idx = -1; cor_idx = -1; rerr_idx = -1;

        // Address and data wrap
        prep(32'hFFFF_FFF8, 4, 1'b1, 32'hFFFF_FFFF, 1'b1);
        finish_chk(1'b1, 1'b0);
        lit_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        lit_d = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
        for (int i = 0; i < 4; i++) begin
            chk("lit_wrap_addr", log_a[i], lit_a[i]);
            chk("lit_wrap_data", log_d[i], lit_d[i]);
        end
        chk("wrap_err_cleared", err_count, 0);

        // Reset during the second write request
        prep(32'h500, 4, 1'b1, 32'h20, 1'b1);
        for (int c = 0; c < 200; c++) begin
            @(posedge ACLK); #1;
            if (wr_idx == 1 && M_AXI_awvalid) break;
        end
        chk("second_wr_req_seen", wr_idx == 1 && M_AXI_awvalid, 1);
        #2 ARESET = 1;
        #1;
        chk("async_rst_valids", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready}, 0);
        chk("async_rst_busy", {busy, done}, 0);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        chk("no_done_on_reset", done_cnt, 0);

        // Clean run after reset, with ignored start pulses while busy
        prep(32'h600, 4, 1'b1, 32'h30, 1'b1);
        finish_chk(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
